// File: rtl/dplca_txop_table.sv
// D-PLCA TXOP occupancy table: clear, aging sweep, free-TXOP pick and hard-claim status.
// Optional macro DPLCA_RANDOM_PICK_EN starts each pick scan at an LFSR-chosen index.
module dplca_txop_table #(
  parameter int NUM_TXOP        = 32,
  parameter int ID_W            = 8,
  parameter int AGE_W           = 4,
  parameter int AGE_MAX         = 15,
  parameter int MAX_HARD_CLAIMS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear_req,
  output logic            clear_done,
  input  logic            age_tick,
  output logic            busy,
  input  logic            obs_valid,
  input  logic [ID_W-1:0] obs_id,
  input  logic            obs_hard,
  input  logic            pick_req,
  output logic            pick_valid,
  output logic [ID_W-1:0] pick_id,
  output logic            pick_none,
  input  logic [ID_W-1:0] hc_id,
  output logic            hc_claimed,
  output logic [ID_W:0]   hard_count,
  output logic            max_hard_claim,
  output logic [1:0]      state_dbg
);

  localparam int IDX_W = $clog2(NUM_TXOP);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TXOP - 1);
  localparam logic [IDX_W-1:0] LAST_SCAN = IDX_W'(NUM_TXOP - 2);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_AGE, S_PICK} state_t;

  // Request handshake: clear_req, age_tick and pick_req are single-cycle pulses with no
  // ready. Clear/age pulses seen while busy are held in one-deep pending flags; pick_req
  // is only honoured when busy=0. Results come back as one-cycle strobes.
  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       scan_cnt;
  logic                   clear_pend;
  logic                   age_pend;
  logic [AGE_W-1:0]       age [NUM_TXOP];
  logic [NUM_TXOP-1:0]    hard;

  logic                   obs_hit;
  logic [IDX_W-1:0]       obs_idx;
  logic                   idx_free;
  logic                   last_idx;
  logic [IDX_W-1:0]       next_idx;
  logic                   hc_ok;
  logic [IDX_W-1:0]       hc_idx;
  logic [ID_W:0]          hard_cnt_c;
  logic [IDX_W-1:0]       pick_start;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  assign obs_idx  = obs_id[IDX_W-1:0];
  assign obs_hit  = obs_valid && (obs_id != '0) && (32'(obs_id) < NUM_TXOP) && (state != S_CLEAR);
  assign last_idx = (idx == LAST_IDX);
  assign next_idx = last_idx ? FIRST_IDX : idx + IDX_W'(1);
  // An entry being observed this very cycle is in use, even if its age is still zero.
  assign idx_free = (age[idx] == '0) && !(obs_hit && (obs_idx == idx));
  assign hc_idx   = hc_id[IDX_W-1:0];
  assign hc_ok    = (hc_id != '0) && (32'(hc_id) < NUM_TXOP);

  always_comb begin
    hard_cnt_c = '0;
    for (int i = 1; i < NUM_TXOP; i++) begin
      hard_cnt_c = hard_cnt_c + {{ID_W{1'b0}}, hard[i]};
    end
  end

`ifdef DPLCA_RANDOM_PICK_EN
  logic [15:0]     lfsr;
  logic [ID_W-1:0] s_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign s_raw      = lfsr[ID_W-1:0];
  assign pick_start = ((s_raw == '0) || (32'(s_raw) >= NUM_TXOP)) ? FIRST_IDX : s_raw[IDX_W-1:0];
`else
  assign pick_start = FIRST_IDX;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= FIRST_IDX;
      scan_cnt       <= '0;
      clear_pend     <= 1'b0;
      age_pend       <= 1'b0;
      clear_done     <= 1'b0;
      pick_valid     <= 1'b0;
      pick_id        <= '0;
      pick_none      <= 1'b0;
      hc_claimed     <= 1'b0;
      hard_count     <= '0;
      max_hard_claim <= 1'b0;
      hard           <= '0;
      for (int i = 0; i < NUM_TXOP; i++) begin
        age[i] <= '0;
      end
    end else begin
      clear_done     <= 1'b0;
      pick_valid     <= 1'b0;
      hc_claimed     <= hc_ok && hard[hc_idx] && (age[hc_idx] != '0);
      hard_count     <= hard_cnt_c;
      max_hard_claim <= (32'(hard_cnt_c) >= MAX_HARD_CLAIMS);

      case (state)
        S_IDLE: begin
          idx      <= FIRST_IDX;
          scan_cnt <= '0;
          if (clear_pend || clear_req) begin
            state      <= S_CLEAR;
            clear_pend <= 1'b0;
            age_pend   <= age_pend || age_tick;
          end else if (age_pend || age_tick) begin
            state    <= S_AGE;
            age_pend <= 1'b0;
          end else if (pick_req) begin
            state <= S_PICK;
            idx   <= pick_start;
          end
        end

        S_CLEAR: begin
          age[idx]  <= '0;
          hard[idx] <= 1'b0;
          if (last_idx) begin
            state      <= S_IDLE;
            clear_done <= 1'b1;
          end else begin
            idx <= next_idx;
          end
        end

        S_AGE: begin
          if (age[idx] != '0) begin
            age[idx] <= age[idx] - AGE_W'(1);
            if (age[idx] == AGE_W'(1)) hard[idx] <= 1'b0;
          end
          if (last_idx) state <= S_IDLE;
          else          idx   <= next_idx;
        end

        S_PICK: begin
          if (idx_free) begin
            age[idx]   <= AGE_W'(AGE_MAX);
            hard[idx]  <= 1'b0;
            pick_valid <= 1'b1;
            pick_id    <= ID_W'(idx);
            pick_none  <= 1'b0;
            state      <= S_IDLE;
          end else if (scan_cnt == LAST_SCAN) begin
            pick_valid <= 1'b1;
            pick_id    <= '0;
            pick_none  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            idx      <= next_idx;
            scan_cnt <= scan_cnt + IDX_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase

      if (state != S_IDLE) begin
        clear_pend <= clear_pend || clear_req;
        age_pend   <= age_pend || age_tick;
      end

      // Placed last so a live observation wins over the sweep or pick write above.
      if (obs_hit) begin
        age[obs_idx]  <= AGE_W'(AGE_MAX);
        hard[obs_idx] <= obs_hard;
      end
    end
  end

endmodule

// File: tb/tb_dplca_txop_table.sv
// Directed bench for dplca_txop_table (default build, NUM_TXOP=32, AGE_MAX=15).
module tb_dplca_txop_table;

  localparam int ID_W = 8;

  logic            clk;
  logic            reset_n;
  logic            clear_req;
  logic            clear_done;
  logic            age_tick;
  logic            busy;
  logic            obs_valid;
  logic [ID_W-1:0] obs_id;
  logic            obs_hard;
  logic            pick_req;
  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            pick_none;
  logic [ID_W-1:0] hc_id;
  logic            hc_claimed;
  logic [ID_W:0]   hard_count;
  logic            max_hard_claim;
  logic [1:0]      state_dbg;

  int total = 0;
  int bad   = 0;

  dplca_txop_table #(
    .NUM_TXOP(32), .ID_W(ID_W), .AGE_W(4), .AGE_MAX(15), .MAX_HARD_CLAIMS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .clear_req(clear_req), .clear_done(clear_done),
    .age_tick(age_tick), .busy(busy),
    .obs_valid(obs_valid), .obs_id(obs_id), .obs_hard(obs_hard),
    .pick_req(pick_req), .pick_valid(pick_valid), .pick_id(pick_id), .pick_none(pick_none),
    .hc_id(hc_id), .hc_claimed(hc_claimed),
    .hard_count(hard_count), .max_hard_claim(max_hard_claim),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic observe(input int id, input logic hard_bit);
    obs_valid = 1'b1;
    obs_id    = ID_W'(id);
    obs_hard  = hard_bit;
    tick();
    obs_valid = 1'b0;
  endtask

  task automatic do_pick(input string tag, input int exp_id, input int exp_none, input int exp_lat);
    int lat;
    pick_req = 1'b1;
    tick();
    pick_req = 1'b0;
    lat = 1;
    while (!pick_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_id"}, pick_id, exp_id);
    check({tag, "_none"}, pick_none, exp_none);
    tick();
    check({tag, "_strobe_width"}, pick_valid, 0);
  endtask

  task automatic age_pass(output int n);
    age_tick = 1'b1;
    tick();
    age_tick = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int first;
    int pulses;

    reset_n = 1'b0; clear_req = 1'b0; age_tick = 1'b0; obs_valid = 1'b0;
    obs_id = '0; obs_hard = 1'b0; pick_req = 1'b0; hc_id = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_pick_valid", pick_valid, 0);
    check("rst_pick_id", pick_id, 0);
    check("rst_pick_none", pick_none, 0);
    check("rst_hc_claimed", hc_claimed, 0);
    check("rst_hard_count", hard_count, 0);
    check("rst_max_hard", max_hard_claim, 0);
    check("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    tick();

    // lowest free entry, then the next one once entry 1 is reserved
    do_pick("pick1", 1, 0, 2);
    do_pick("pick2", 2, 0, 3);

    // hard-claim count across the MAX_HARD_CLAIMS boundary, then a full table
    for (int i = 1; i <= 3; i++) observe(i, 1'b1);
    settle();
    check("hc_cnt3", hard_count, 3);
    check("max_at3", max_hard_claim, 0);
    observe(4, 1'b1);
    settle();
    check("hc_cnt4", hard_count, 4);
    check("max_at4", max_hard_claim, 1);
    for (int i = 5; i <= 31; i++) observe(i, 1'b1);
    settle();
    check("hc_cnt31", hard_count, 31);
    check("max_at31", max_hard_claim, 1);
    do_pick("pick_full", 0, 1, 32);

    // hard-claim query and aging to empty
    observe(5, 1'b1);
    hc_id = 8'd5;
    settle();
    check("hc5_claimed", hc_claimed, 1);
    age_pass(n);
    check("age_pass_len", n, 31);
    for (int p = 2; p <= 14; p++) age_pass(n);
    settle();
    check("hc5_after14", hc_claimed, 1);
    check("hcnt_after14", hard_count, 31);
    age_pass(n);
    settle();
    check("hc5_after15", hc_claimed, 0);
    check("hcnt_after15", hard_count, 0);
    check("max_after15", max_hard_claim, 0);
    do_pick("pick_aged", 1, 0, 2);

    // clear requested 3 cycles into an aging sweep is held and runs afterwards
    observe(9, 1'b1);
    settle();
    check("hcnt_pre_clear", hard_count, 1);
    age_tick = 1'b1;
    tick();
    age_tick = 1'b0;
    tick();
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    first = -1;
    pulses = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (clear_done) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("clear_done_cycle", first, 60);
    check("clear_done_pulses", pulses, 1);
    hc_id = 8'd9;
    settle();
    check("hc9_after_clear", hc_claimed, 0);
    check("hcnt_after_clear", hard_count, 0);
    do_pick("pick_cleared", 1, 0, 2);

    // out-of-range observations are ignored
    observe(0, 1'b1);
    observe(40, 1'b1);
    hc_id = 8'd40;
    settle();
    check("hcnt_bad_obs", hard_count, 0);
    check("hc40", hc_claimed, 0);
    hc_id = 8'd8;
    settle();
    check("hc8_alias", hc_claimed, 0);
    hc_id = 8'd0;
    settle();
    check("hc0", hc_claimed, 0);

    // observation at the sweep index wins over the decrement
    age_tick = 1'b1;
    tick();
    age_tick = 1'b0;
    check("state_age", state_dbg, 2);
    repeat (6) tick();
    observe(7, 1'b1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    for (int p = 1; p <= 14; p++) age_pass(n);
    hc_id = 8'd7;
    settle();
    check("hc7_after14", hc_claimed, 1);
    age_pass(n);
    settle();
    check("hc7_after15", hc_claimed, 0);

    // asynchronous reset in the middle of a sweep
    observe(1, 1'b1);
    observe(3, 1'b1);
    settle();
    check("hcnt_pre_rst", hard_count, 2);
    age_tick = 1'b1;
    tick();
    age_tick = 1'b0;
    repeat (4) tick();
    check("busy_mid_sweep", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hcnt", hard_count, 0);
    check("rst_mid_state", state_dbg, 0);
    tick();
    reset_n = 1'b1;
    hc_id = 8'd3;
    settle();
    check("hc3_after_rst", hc_claimed, 0);
    check("hcnt_after_rst", hard_count, 0);
    do_pick("pick_after_rst", 1, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dplca_txop_table.md
Name: dplca_txop_table

Overview:
Synchronous RTL TXOP occupancy table for D-PLCA (IEEE P802.3da Clause 148).
- Provides, in hardware, the table clear, hard-claim query, max-hard-claim and free-TXOP pick services that the Clause 148 state diagrams need.
- Parametrised in table depth, age width and hard-claim limit; adds aging sweeps, reserved-on-pick and a failure indication.
- Sits beside the D-PLCA control and TXOP-claim state diagrams. It is fed by observed beacons and transmit opportunities.

Parameters:
- NUM_TXOP, 32, table entries (2..256); index 0 is the coordinator and is permanently occupied.
- ID_W, 8, nodeID/TXOP index width.
- AGE_W, 4, per-entry age counter width.
- AGE_MAX, 15, age loaded on observe/pick (must be ≤ 2^AGE_W−1).
- MAX_HARD_CLAIMS, 4, threshold for max_hard_claim.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- clear_req, in, 1, request a full table clear (pulse).
- clear_done, out, 1, one-cycle pulse when a clear completes.
- age_tick, in, 1, request one aging pass (pulse).
- busy, out, 1, FSM not IDLE.
- obs_valid, in, 1, TXOP usage observed.
- obs_id, in, ID_W, observed TXOP index.
- obs_hard, in, 1, observed usage is a hard claim.
- pick_req, in, 1, request a free TXOP (pulse; accepted only when busy=0).
- pick_valid, out, 1, one-cycle pick result strobe.
- pick_id, out, ID_W, picked TXOP index.
- pick_none, out, 1, qualifies pick_valid: no free entry.
- hc_id, in, ID_W, hard-claim query index.
- hc_claimed, out, 1, registered: hc_id entry occupied and hard.
- hard_count, out, ID_W+1, registered count of hard-claimed entries.
- max_hard_claim, out, 1, registered: hard_count ≥ MAX_HARD_CLAIMS.

Behaviour:
- Storage per entry: age[AGE_W] and hard[1]. An entry is free iff age==0. Entry 0 is never written, never free and never picked.
- Reset (async, any time, including mid-sweep):
  - all age/hard cleared; FSM→IDLE; pending flags cleared.
  - all outputs 0: busy, clear_done, pick_valid, pick_id, pick_none, hc_claimed, hard_count, max_hard_claim.
- FSM states IDLE, CLEAR, AGE, PICK. Sweep index idx runs 1..NUM_TXOP−1, one entry per cycle.
- IDLE priority: pending/new clear > pending/new age_tick > pick_req.
- clear_req or age_tick arriving while busy sets a one-deep pending flag; repeats coalesce. pick_req while busy is ignored.
- CLEAR:
  - writes age=0, hard=0 at idx; NUM_TXOP−1 cycles.
  - clear_done pulses in the cycle after the last write; FSM→IDLE.
  - obs_valid during CLEAR is dropped.
- AGE:
  - at idx, if age≠0 then age−1.
  - age reaching 0 also clears hard.
  - NUM_TXOP−1 cycles, then →IDLE.
- Observe (any state except CLEAR):
  - if obs_valid and 1≤obs_id<NUM_TXOP, then age=AGE_MAX and hard=obs_hard.
  - observe overrides an AGE decrement or PICK reservation at the same index in the same cycle.
  - obs_id 0 and obs_id ≥ NUM_TXOP are ignored.
- PICK:
  - starts at start index s (see Optional Feature) and scans one entry per cycle, wrapping from NUM_TXOP−1 to 1.
  - on the first free entry: reserve it (age=AGE_MAX, hard=0), and the next cycle pulse pick_valid with pick_id=index, pick_none=0; →IDLE.
  - if an observe hits the scanned index in that cycle, it is not free; the scan continues.
  - after NUM_TXOP−1 entries with none free: pick_valid=1, pick_none=1, pick_id=0.
  - latency = entries scanned + 1 cycles.
- hc_claimed <= (1≤hc_id<NUM_TXOP) & hard[hc_id] & (age[hc_id]≠0); 1-cycle latency.
- hard_count <= popcount(hard[1..NUM_TXOP−1]) each cycle; max_hard_claim is computed from that same count in the same cycle.
- Counters never wrap: age saturates at 0 on decrement.

Optional Feature:
- Macro: DPLCA_RANDOM_PICK_EN.
- Defined:
  - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded 16'hACE1 at reset, advances every clk.
  - on pick acceptance, s = lfsr[ID_W−1:0]; if s==0 or s ≥ NUM_TXOP, then s=1.
- Undefined: s=1 always (lowest free entry, deterministic); no LFSR logic.

Test Plan:
- Reset, then pick_req → pick_valid after 2 cycles, pick_id=1. Second pick_req → pick_id=2 after 3 cycles (entry 1 reserved).
- obs_hard=1 on ids 1..31 → hard_count=31, max_hard_claim=1. Then pick_req → after 32 cycles pick_valid=1, pick_none=1, pick_id=0.
- obs id 5 hard, hc_id=5 → hc_claimed=1. Then 15 age_tick passes (each 31 cycles) → hc_claimed=0, hard_count=0, and the next pick_req returns pick_id=1 (random pick disabled).
- age_tick, then clear_req 3 cycles later → AGE sweep completes, CLEAR runs, clear_done pulses once. All entries are then free; hard_count=0.
- obs_id=0 and obs_id=40 (NUM_TXOP=32) → no state change; hc_id=40 → hc_claimed=0.
- During an AGE sweep, obs at the same index idx=7 in the same cycle → age[7]=15, not 14. Assert reset_n low mid-sweep → busy=0 and the table is empty.
